ireg_skew_bank: RTL and testbench

- Multi-channel horizontal input register bank at the west edge of the unary-rate systolic array.
- Accepts one data word per row per cycle, aligned in time across rows.
- Applies the triangular skew the array needs: row c is delayed c extra cycles.
- Carries a valid flag and a sign-load token alongside the data, so each row's sign register updates exactly when its skewed data arrives.

---
 rtl/ireg_pkg.sv | 30 +++
 rtl/ireg_delay_line.sv | 154 +++++++++++++++
 rtl/ireg_skew_bank.sv | 63 ++++++
 tb/tb_ireg_skew_bank.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ireg_pkg.sv
// ---------------------------------------------------------------------------
// ireg_pkg
// Shared types and helpers for the west-edge input register bank of the
// unary-rate systolic array.
//   IREG_DATA_W : default data width of one row
//   stage_t     : one pipeline stage record {valid, sign_ld, sign, data}
//   skew_depth  : number of internal skew stages for a given row
// ---------------------------------------------------------------------------
package ireg_pkg;

    localparam int unsigned IREG_DATA_W = 16;

    typedef struct packed {
        logic                   valid;
        logic                   sign_ld;
        logic                   sign;
        logic [IREG_DATA_W-1:0] data;
    } stage_t;

    // Row c sits c stages deep in the triangular skew; without skew every
    // row goes straight into its output register.
    function automatic int unsigned skew_depth(input int unsigned c, input bit skew_en);
        if (skew_en) begin
            return c;
        end else begin
            return 32'd0;
        end
    endfunction

endpackage

// File: rtl/ireg_delay_line.sv
// ---------------------------------------------------------------------------
// ireg_delay_line
// One row of the skew bank: DEPTH internal stages followed by the output
// register. DEPTH=0 leaves only the output register.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   en_i                advance enable (hold everything when low)
//   clr_i               synchronous clear, wins over en_i
//   valid_i, data_i,
//   sign_ld_i, sign_i   stage record entering the row
//   valid_o, data_o,
//   sign_o              registered row outputs
//   busy_o              registered: a token is still inside the internal stages
// ---------------------------------------------------------------------------
module ireg_delay_line
    import ireg_pkg::*;
#(
    parameter int unsigned DEPTH = 0,
    parameter int unsigned WIDTH = IREG_DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             sign_ld_i,
    input  logic             sign_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             sign_o,
    output logic             busy_o
);

    // Local record type so the data field follows this instance's WIDTH.
    typedef struct packed {
        logic             valid;
        logic             sign_ld;
        logic             sign;
        logic [WIDTH-1:0] data;
    } row_stage_t;

    row_stage_t       in_s;
    row_stage_t       tail_s;
    logic             busy_d;
    logic             busy_q;
    logic             valid_d;
    logic             valid_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             sign_d;
    logic             sign_q;

    assign in_s = '{valid: valid_i, sign_ld: sign_ld_i, sign: sign_i, data: data_i};

    if (DEPTH == 0) begin : g_direct
        assign tail_s = in_s;
        assign busy_d = 1'b0;
    end else begin : g_chain
        row_stage_t stage_q [DEPTH];
        row_stage_t stage_d [DEPTH];

        // Shift the chain one stage per enabled cycle; busy is taken from the
        // post-update contents so it lines up with the registered stages.
        always_comb begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_d[i] = stage_q[i];
            end
            if (clr_i) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_d[i] = '0;
                end
            end else if (en_i) begin
                stage_d[0] = in_s;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end else begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_d[i] = stage_q[i];
                end
            end
            busy_d = 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                busy_d = busy_d | stage_d[i].valid | stage_d[i].sign_ld;
            end
        end

        // Skew stage registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign tail_s = stage_q[DEPTH-1];
    end

    // Output register next state: data and sign only move when their own
    // token is present, so the sign stays aligned with its data word.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sign_d  = sign_q;
        if (clr_i) begin
            valid_d = 1'b0;
            data_d  = '0;
            sign_d  = 1'b0;
        end else if (en_i) begin
            valid_d = tail_s.valid;
            if (tail_s.valid) begin
                data_d = tail_s.data;
            end else begin
                data_d = data_q;
            end
            if (tail_s.sign_ld) begin
                sign_d = tail_s.sign;
            end else begin
                sign_d = sign_q;
            end
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
            sign_d  = sign_q;
        end
    end

    // Output and busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sign_q  <= sign_d;
            busy_q  <= busy_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign sign_o  = sign_q;
    assign busy_o  = busy_q;

endmodule

// File: rtl/ireg_skew_bank.sv
// ---------------------------------------------------------------------------
// ireg_skew_bank
// Horizontal input register bank at the west edge of the systolic array.
// Time-aligned row words enter together; row c leaves D(c)+1 enabled cycles
// later (D(c)=c with skew, 0 without), carrying valid and a sign-load token.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   en, clr         advance enable, synchronous clear (clr wins)
//   i_valid         shared input valid
//   i_data          row c at [c*WIDTH +: WIDTH]
//   i_sign          per-row sign value
//   i_sign_ld       load i_sign alongside this cycle's data
//   o_valid/o_data  per-row skewed valid and held data
//   o_sign          per-row held sign
//   o_busy          a token is still inside the skew stages
// ---------------------------------------------------------------------------
module ireg_skew_bank
    import ireg_pkg::*;
#(
    parameter int unsigned CH      = 4,
    parameter int unsigned WIDTH   = IREG_DATA_W,
    parameter bit          SKEW_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic                i_valid,
    input  logic [CH*WIDTH-1:0] i_data,
    input  logic [CH-1:0]       i_sign,
    input  logic                i_sign_ld,
    output logic [CH-1:0]       o_valid,
    output logic [CH*WIDTH-1:0] o_data,
    output logic [CH-1:0]       o_sign,
    output logic                o_busy
);

    logic [CH-1:0] row_busy_s;

    for (genvar c = 0; c < CH; c++) begin : g_row
        ireg_delay_line #(
            .DEPTH (skew_depth(c, SKEW_EN)),
            .WIDTH (WIDTH)
        ) u_line (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (en),
            .clr_i     (clr),
            .valid_i   (i_valid),
            .data_i    (i_data[c*WIDTH +: WIDTH]),
            .sign_ld_i (i_sign_ld),
            .sign_i    (i_sign[c]),
            .valid_o   (o_valid[c]),
            .data_o    (o_data[c*WIDTH +: WIDTH]),
            .sign_o    (o_sign[c]),
            .busy_o    (row_busy_s[c])
        );
    end

    // Each row flag is already a register, so the OR stays glitch-free.
    assign o_busy = |row_busy_s;

endmodule

// File: tb/tb_ireg_skew_bank.sv
// ---------------------------------------------------------------------------
// tb_ireg_skew_bank
// Directed bench for ireg_skew_bank with CH=4, WIDTH=16. A skewed and an
// unskewed instance share the same stimulus. Expected per-cycle outputs are
// queued with the stimulus and popped after each clock edge.
// ---------------------------------------------------------------------------
module tb_ireg_skew_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        i_valid;
    logic [63:0] i_data;
    logic [3:0]  i_sign;
    logic        i_sign_ld;

    logic [3:0]  o_valid;
    logic [63:0] o_data;
    logic [3:0]  o_sign;
    logic        o_busy;
    logic [3:0]  ns_valid;
    logic [63:0] ns_data;
    logic [3:0]  ns_sign;
    logic        ns_busy;

    typedef struct {
        int          cyc;
        bit          ns;
        logic [3:0]  v;
        logic [63:0] d;
        logic [3:0]  s;
        logic        b;
    } exp_t;

    exp_t q [$];
    int   cyc         = 0;
    int   base        = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    ireg_skew_bank #(.CH(4), .WIDTH(16), .SKEW_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .i_valid(i_valid), .i_data(i_data), .i_sign(i_sign), .i_sign_ld(i_sign_ld),
        .o_valid(o_valid), .o_data(o_data), .o_sign(o_sign), .o_busy(o_busy)
    );

    ireg_skew_bank #(.CH(4), .WIDTH(16), .SKEW_EN(1'b0)) dut_ns (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .i_valid(i_valid), .i_data(i_data), .i_sign(i_sign), .i_sign_ld(i_sign_ld),
        .o_valid(ns_valid), .o_data(ns_data), .o_sign(ns_sign), .o_busy(ns_busy)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input int off, input bit ns, input logic [3:0] v,
                            input logic [63:0] d, input logic [3:0] s, input logic b);
        exp_t e;
        e.cyc = base + off;
        e.ns  = ns;
        e.v   = v;
        e.d   = d;
        e.s   = s;
        e.b   = b;
        q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            if (!e.ns) begin
                chk("skew_valid", {60'd0, o_valid}, {60'd0, e.v});
                chk("skew_data",  o_data,           e.d);
                chk("skew_sign",  {60'd0, o_sign},  {60'd0, e.s});
                chk("skew_busy",  {63'd0, o_busy},  {63'd0, e.b});
            end else begin
                chk("noskew_valid", {60'd0, ns_valid}, {60'd0, e.v});
                chk("noskew_data",  ns_data,           e.d);
                chk("noskew_sign",  {60'd0, ns_sign},  {60'd0, e.s});
                chk("noskew_busy",  {63'd0, ns_busy},  {63'd0, e.b});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; i_valid = 1'b0;
        i_data = 64'd0; i_sign = 4'd0; i_sign_ld = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset / idle with en low: everything stays zero.
        base = cyc;
        for (int k = 1; k <= 5; k++) begin
            push_exp(k, 1'b0, 4'b0000, 64'd0, 4'b0000, 1'b0);
            push_exp(k, 1'b1, 4'b0000, 64'd0, 4'b0000, 1'b0);
        end
        repeat (5) tick();

        // Skew alignment: row c valid at cycle c+1; no-skew all at cycle 1.
        base = cyc;
        push_exp(1, 1'b0, 4'b0001, 64'h0000_0000_0000_0000, 4'b0000, 1'b1);
        push_exp(1, 1'b1, 4'b1111, 64'h0003_0002_0001_0000, 4'b0000, 1'b0);
        push_exp(2, 1'b0, 4'b0010, 64'h0000_0000_0001_0000, 4'b0000, 1'b1);
        push_exp(2, 1'b1, 4'b0000, 64'h0003_0002_0001_0000, 4'b0000, 1'b0);
        push_exp(3, 1'b0, 4'b0100, 64'h0000_0002_0001_0000, 4'b0000, 1'b1);
        push_exp(3, 1'b1, 4'b0000, 64'h0003_0002_0001_0000, 4'b0000, 1'b0);
        push_exp(4, 1'b0, 4'b1000, 64'h0003_0002_0001_0000, 4'b0000, 1'b0);
        push_exp(4, 1'b1, 4'b0000, 64'h0003_0002_0001_0000, 4'b0000, 1'b0);
        push_exp(5, 1'b0, 4'b0000, 64'h0003_0002_0001_0000, 4'b0000, 1'b0);
        push_exp(5, 1'b1, 4'b0000, 64'h0003_0002_0001_0000, 4'b0000, 1'b0);
        en = 1'b1; i_valid = 1'b1; i_data = 64'h0003_0002_0001_0000;
        tick();
        i_valid = 1'b0; i_data = 64'd0;
        repeat (4) tick();

        // Sign token travels with its data word.
        base = cyc;
        push_exp(1, 1'b0, 4'b0001, 64'h0003_0002_0001_A000, 4'b0000, 1'b1);
        push_exp(1, 1'b1, 4'b1111, 64'hA003_A002_A001_A000, 4'b1010, 1'b0);
        push_exp(2, 1'b0, 4'b0010, 64'h0003_0002_A001_A000, 4'b0010, 1'b1);
        push_exp(2, 1'b1, 4'b0000, 64'hA003_A002_A001_A000, 4'b1010, 1'b0);
        push_exp(3, 1'b0, 4'b0100, 64'h0003_A002_A001_A000, 4'b0010, 1'b1);
        push_exp(3, 1'b1, 4'b0000, 64'hA003_A002_A001_A000, 4'b1010, 1'b0);
        push_exp(4, 1'b0, 4'b1000, 64'hA003_A002_A001_A000, 4'b1010, 1'b0);
        push_exp(4, 1'b1, 4'b0000, 64'hA003_A002_A001_A000, 4'b1010, 1'b0);
        i_valid = 1'b1; i_data = 64'hA003_A002_A001_A000; i_sign = 4'b1010; i_sign_ld = 1'b1;
        tick();
        i_valid = 1'b0; i_data = 64'd0; i_sign_ld = 1'b0;
        repeat (3) tick();

        // Enable stall: three held cycles, row 3 arrives at cycle 7.
        base = cyc;
        for (int k = 1; k <= 4; k++) begin
            push_exp(k, 1'b0, 4'b0001, 64'hA003_A002_A001_BEEF, 4'b1010, 1'b1);
            push_exp(k, 1'b1, 4'b1111, 64'hBEEF_BEEF_BEEF_BEEF, 4'b1010, 1'b0);
        end
        push_exp(5, 1'b0, 4'b0010, 64'hA003_A002_BEEF_BEEF, 4'b1010, 1'b1);
        push_exp(5, 1'b1, 4'b0000, 64'hBEEF_BEEF_BEEF_BEEF, 4'b1010, 1'b0);
        push_exp(6, 1'b0, 4'b0100, 64'hA003_BEEF_BEEF_BEEF, 4'b1010, 1'b1);
        push_exp(6, 1'b1, 4'b0000, 64'hBEEF_BEEF_BEEF_BEEF, 4'b1010, 1'b0);
        push_exp(7, 1'b0, 4'b1000, 64'hBEEF_BEEF_BEEF_BEEF, 4'b1010, 1'b0);
        push_exp(7, 1'b1, 4'b0000, 64'hBEEF_BEEF_BEEF_BEEF, 4'b1010, 1'b0);
        push_exp(8, 1'b0, 4'b0000, 64'hBEEF_BEEF_BEEF_BEEF, 4'b1010, 1'b0);
        push_exp(8, 1'b1, 4'b0000, 64'hBEEF_BEEF_BEEF_BEEF, 4'b1010, 1'b0);
        i_valid = 1'b1; i_data = 64'hBEEF_BEEF_BEEF_BEEF;
        tick();
        i_valid = 1'b0; i_data = 64'd0; en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        repeat (4) tick();

        // Clear priority: clr with en and a valid/sign-load input wipes all.
        base = cyc;
        push_exp(1, 1'b0, 4'b0001, 64'hBEEF_BEEF_BEEF_1111, 4'b1010, 1'b1);
        push_exp(1, 1'b1, 4'b1111, 64'h1111_1111_1111_1111, 4'b1010, 1'b0);
        push_exp(2, 1'b0, 4'b0011, 64'hBEEF_BEEF_1111_2222, 4'b1010, 1'b1);
        push_exp(2, 1'b1, 4'b1111, 64'h2222_2222_2222_2222, 4'b1010, 1'b0);
        for (int k = 3; k <= 6; k++) begin
            push_exp(k, 1'b0, 4'b0000, 64'd0, 4'b0000, 1'b0);
            push_exp(k, 1'b1, 4'b0000, 64'd0, 4'b0000, 1'b0);
        end
        i_valid = 1'b1; i_data = 64'h1111_1111_1111_1111;
        tick();
        i_data = 64'h2222_2222_2222_2222;
        tick();
        clr = 1'b1; i_data = 64'h3333_3333_3333_3333; i_sign = 4'b0101; i_sign_ld = 1'b1;
        tick();
        clr = 1'b0; i_valid = 1'b0; i_data = 64'd0; i_sign_ld = 1'b0;
        repeat (3) tick();

        // Async reset mid-stream drops in-flight tokens.
        base = cyc;
        push_exp(1, 1'b0, 4'b0001, 64'h0000_0000_0000_5555, 4'b0000, 1'b1);
        push_exp(1, 1'b1, 4'b1111, 64'h5555_5555_5555_5555, 4'b0000, 1'b0);
        push_exp(2, 1'b0, 4'b0000, 64'd0, 4'b0000, 1'b0);
        push_exp(2, 1'b1, 4'b0000, 64'd0, 4'b0000, 1'b0);
        push_exp(3, 1'b0, 4'b0000, 64'd0, 4'b0000, 1'b0);
        push_exp(3, 1'b1, 4'b0000, 64'd0, 4'b0000, 1'b0);
        i_valid = 1'b1; i_data = 64'h5555_5555_5555_5555; i_sign = 4'b0000;
        tick();
        i_valid = 1'b0; i_data = 64'd0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();

        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
